// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the SRAM-like bus. Requests land in
// a word-organised memory; every accepted request queues one response entry
// that is returned in order after a fixed minimum latency.
//
// Handshake: a request transfers on a rising edge where req && addr_ok.
// addr_ok depends only on registered occupancy and addr_stall, never on req.
// Until it is accepted, the initiator holds req and the payload steady.
// data_ok is a one-cycle pulse per accepted request. It has no ready and
// cannot be stalled.
module sram_like_responder #(
  parameter int AW      = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req,
  input  logic                       wr,
  input  logic [1:0]                 size,
  input  logic [3:0]                 wstrb,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic                       addr_stall,
  output logic                       addr_ok,
  output logic                       data_ok,
  output logic [31:0]                rdata,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  // The countdown only needs to hold LATENCY-1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CD_INIT = CW'(LATENCY - 1);
  localparam logic [OW-1:0] FULL    = OW'(DEPTH);

  // Backing store. It is deliberately not reset, so contents survive resetn.
  logic [31:0] mem [2**AW];

  logic [AW-1:0] widx;
  logic          push;
  logic          pop;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [OW-1:0] count;

  // Response entries in a circular FIFO.
  logic          ent_vld  [DEPTH];
  logic          ent_rd   [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [CW-1:0] ent_cd   [DEPTH];

  // size and the address bits outside the word index do not affect behaviour.
  logic unused_bits;

  assign widx        = addr[AW+1:2];
  assign addr_ok     = (count != FULL) && !addr_stall;
  assign push        = req && addr_ok;
  assign pop         = (count != '0) && (ent_cd[rptr] == '0);
  assign outstanding = count;
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  // Byte-masked memory write on an accepted write request.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Response queue: count down entries, push on accept, pop/issue the ready head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_vld[i]  <= 1'b0;
        ent_rd[i]   <= 1'b0;
        ent_data[i] <= '0;
        ent_cd[i]   <= '0;
      end
    end else begin
      // Every live entry ages each edge, saturating at zero.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && (ent_cd[i] != '0)) begin
          ent_cd[i] <= ent_cd[i] - 1'b1;
        end
      end

      data_ok <= pop;
      if (pop) begin
        ent_vld[rptr] <= 1'b0;
        rptr          <= rptr + 1'b1;
        rdata         <= ent_rd[rptr] ? ent_data[rptr] : 32'h0;
      end

      // A push and a pop never target the same slot: that would need the
      // queue to be both full (no push) and empty (no pop).
      if (push) begin
        ent_vld[wptr]  <= 1'b1;
        ent_rd[wptr]   <= !wr;
        ent_data[wptr] <= wr ? 32'h0 : mem[widx];
        ent_cd[wptr]   <= CD_INIT;
        wptr           <= wptr + 1'b1;
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder (DEPTH=4, LATENCY=4).
module tb_sram_like_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          resetn;
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [3:0]    wstrb;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          addr_stall;
  logic          addr_ok;
  logic          data_ok;
  logic [31:0]   rdata;
  logic [OW-1:0] outstanding;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int          edge_n        = 0;
  int          acc_total     = 0;
  int          resp_total    = 0;
  int          last_resp     = 0;
  int          last_acc_edge = 0;
  logic [31:0] exp_q[$];
  int          exp_e_q[$];
  logic [31:0] mem_m [2**AW];
  logic [31:0] mon_d;
  int          mon_e;

  sram_like_responder #(.AW(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .wr          (wr),
    .size        (size),
    .wstrb       (wstrb),
    .addr        (addr),
    .wdata       (wdata),
    .addr_stall  (addr_stall),
    .addr_ok     (addr_ok),
    .data_ok     (data_ok),
    .rdata       (rdata),
    .outstanding (outstanding)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n++;

  // Response monitor: pops the scoreboard on every data_ok and checks occupancy.
  always @(negedge clk) begin
    if (data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_data_ok edge=%0d rdata=%h", edge_n, rdata);
      end else begin
        mon_d = exp_q.pop_front();
        mon_e = exp_e_q.pop_front();
        resp_total++;
        vectors++;
        if (rdata !== mon_d) begin
          miscompares++;
          $display("FAIL resp_rdata edge=%0d got %h expected %h", edge_n, rdata, mon_d);
        end
        vectors++;
        if (edge_n != mon_e) begin
          miscompares++;
          $display("FAIL resp_edge got edge %0d expected edge %0d", edge_n, mon_e);
        end
      end
    end else if (exp_e_q.size() != 0) begin
      vectors++;
      if (edge_n >= exp_e_q[0]) begin
        miscompares++;
        $display("FAIL resp_missing edge=%0d expected at edge %0d", edge_n, exp_e_q[0]);
        mon_d = exp_q.pop_front();
        mon_e = exp_e_q.pop_front();
      end
    end
    vectors++;
    if (outstanding !== OW'(acc_total - resp_total)) begin
      miscompares++;
      $display("FAIL outstanding edge=%0d got %0d expected %0d", edge_n, outstanding,
               acc_total - resp_total);
    end
  end

  // Driver: hold a request until accepted, checking addr_ok every cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] strb, input logic [3:0] stall_pat, output int tries);
    logic          done;
    logic          exp_ok;
    int            e;
    int            r;
    logic [AW-1:0] wi;
    done  = 1'b0;
    tries = 0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      req        = 1'b1;
      wr         = w;
      size       = 2'd2;
      wstrb      = strb;
      addr       = a;
      wdata      = d;
      addr_stall = (t < 4) ? stall_pat[t[1:0]] : 1'b0;
      #1;
      exp_ok = ((acc_total - resp_total) != DEPTH) && !addr_stall;
      vectors++;
      if (addr_ok !== exp_ok) begin
        miscompares++;
        $display("FAIL addr_ok t=%0t got %b expected %b", $time, addr_ok, exp_ok);
      end
      if (addr_ok === 1'b1) begin
        done  = 1'b1;
        tries = t + 1;
        wi    = a[AW+1:2];
        e     = edge_n + 1;
        r     = (e + LAT > last_resp + 1) ? e + LAT : last_resp + 1;
        last_resp     = r;
        last_acc_edge = e;
        acc_total++;
        if (w) begin
          for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem_m[wi][8*b +: 8] = d[8*b +: 8];
          end
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back(mem_m[wi]);
        end
        exp_e_q.push_back(r);
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout addr=%h got no accept expected accept", a);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req        = 1'b0;
    addr_stall = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending %0d expected 0", exp_q.size());
    end
  endtask

  task automatic wait_resp(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #2;
      if (data_ok === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; addr_stall = 1'b0;
    #1 resetn = 1'b0;
    #1;
    vectors++;
    if (data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_data_ok got %b expected 0", data_ok); end
    vectors++;
    if (outstanding !== '0) begin miscompares++; $display("FAIL rst_outstanding got %0d expected 0", outstanding); end
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h expected 0", rdata); end
    vectors++;
    if (addr_ok !== 1'b1) begin miscompares++; $display("FAIL rst_addr_ok got %b expected 1", addr_ok); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    int   tries;
    int   e0;
    logic seen;
    issue(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 4'h0, tries);
    idle();
    drain();
    issue(1'b0, 32'h40, 32'h0, 4'h0, 4'h0, tries);
    e0 = last_acc_edge;
    idle();
    #2;
    vectors++;
    if (outstanding !== OW'(1)) begin miscompares++; $display("FAIL single_outstanding got %0d expected 1", outstanding); end
    wait_resp(seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL single_seen got none expected data_ok"); end
    vectors++;
    if (edge_n - e0 != LAT) begin miscompares++; $display("FAIL single_latency got %0d expected %0d", edge_n - e0, LAT); end
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rdata got %h expected deadbeef", rdata); end
    vectors++;
    if (outstanding !== '0) begin miscompares++; $display("FAIL single_outstanding_after got %0d expected 0", outstanding); end
    drain();
  endtask

  task automatic test_byte_write();
    int   tries;
    logic seen;
    issue(1'b1, 32'h40, 32'h0000AB00, 4'b0010, 4'h0, tries);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 4'h0, tries);
    idle();
    wait_resp(seen);
    vectors++;
    if (!seen || rdata !== 32'h0) begin miscompares++; $display("FAIL bw_write_resp got seen=%b rdata=%h expected 1/0", seen, rdata); end
    @(negedge clk);
    #2;
    vectors++;
    if (data_ok !== 1'b1 || rdata !== 32'hDEADABEF) begin
      miscompares++;
      $display("FAIL bw_read_resp got data_ok=%b rdata=%h expected 1/deadabef", data_ok, rdata);
    end
    @(negedge clk);
    #2;
    vectors++;
    if (data_ok !== 1'b0 || rdata !== 32'hDEADABEF) begin
      miscompares++;
      $display("FAIL bw_hold got data_ok=%b rdata=%h expected 0/deadabef", data_ok, rdata);
    end
    drain();
  endtask

  task automatic test_full();
    int tries;
    int blocked;
    blocked = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 32'h40, 32'h0, 4'h0, 4'h0, tries);
      blocked += tries - 1;
    end
    idle();
    vectors++;
    if (blocked != 1) begin miscompares++; $display("FAIL full_blocked got %0d expected 1", blocked); end
    drain();
  endtask

  task automatic test_wrap();
    int tries;
    int r0;
    for (int i = 0; i < 20; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 4'h0, tries);
    idle();
    drain();
    r0 = resp_total;
    for (int i = 0; i < 20; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0, 4'h0, tries);
    idle();
    drain();
    vectors++;
    if (resp_total - r0 != 20) begin miscompares++; $display("FAIL wrap_count got %0d expected 20", resp_total - r0); end
  endtask

  task automatic test_stall();
    int t1;
    int t2;
    issue(1'b0, 32'h8, 32'h0, 4'h0, 4'b0001, t1);
    issue(1'b0, 32'hC, 32'h0, 4'h0, 4'b0001, t2);
    idle();
    vectors++;
    if (t1 != 2 || t2 != 2) begin miscompares++; $display("FAIL stall_tries got %0d,%0d expected 2,2", t1, t2); end
    drain();
  endtask

  task automatic test_random();
    int          tries;
    logic        w;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      issue(w, a, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), tries);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
  endtask

  task automatic test_reset_mid();
    int   tries;
    logic seen;
    issue(1'b1, 32'h14, 32'h12345678, 4'hF, 4'h0, tries);
    issue(1'b0, 32'h14, 32'h0, 4'h0, 4'h0, tries);
    idle();
    drain();
    issue(1'b0, 32'h4, 32'h0, 4'h0, 4'h0, tries);
    issue(1'b0, 32'h8, 32'h0, 4'h0, 4'h0, tries);
    issue(1'b0, 32'hC, 32'h0, 4'h0, 4'h0, tries);
    @(negedge clk);
    req = 1'b0;
    #2 resetn = 1'b0;
    exp_q.delete();
    exp_e_q.delete();
    acc_total  = 0;
    resp_total = 0;
    last_resp  = 0;
    #1;
    vectors++;
    if (data_ok !== 1'b0 || outstanding !== '0 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset got data_ok=%b out=%0d rdata=%h expected 0/0/0", data_ok, outstanding, rdata);
    end
    vectors++;
    if (addr_ok !== 1'b1) begin miscompares++; $display("FAIL mid_reset_addr_ok got %b expected 1", addr_ok); end
    addr_stall = 1'b1;
    #1;
    vectors++;
    if (addr_ok !== 1'b0) begin miscompares++; $display("FAIL mid_reset_stall got %b expected 0", addr_ok); end
    addr_stall = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    issue(1'b0, 32'h14, 32'h0, 4'h0, 4'h0, tries);
    vectors++;
    if (tries != 1) begin miscompares++; $display("FAIL first_accept got tries %0d expected 1", tries); end
    idle();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      #2;
      vectors++;
      if (data_ok !== 1'b0) begin miscompares++; $display("FAIL stale_data_ok got %b expected 0", data_ok); end
    end
    wait_resp(seen);
    vectors++;
    if (!seen || rdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL mem_retained got seen=%b rdata=%h expected 1/12345678", seen, rdata);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_full();
    test_wrap();
    test_stall();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
